bus_forkjoin_ctrl: RTL and testbench
====================================

// Module: bus_forkjoin_ctrl
// PURPOSE
//  Single-master controller for a multi-slave forkjoin bus.
//  - Accepts one read/write transaction from the master and broadcasts it to all N_SLAVES (fork).
//  - Waits until every slave has acknowledged (join).
//  - Resolves which slave claimed the address and returns read data plus a status code.
//  - Sits between the bus master and the slave-side exported task handlers.
// PARAMETERS
//  N_SLAVES  4   number of slaves on the bus (>=1)
//  AW        8   address width
//  DW        8   data width
//  TIMEOUT   16  max JOIN cycles before abort (>=2); timer width $clog2(TIMEOUT+1)
// PORTS
//  clock     in   1           bus clock, all logic on rising edge
//  reset_n   in   1           asynchronous active-low reset
//  m_req     in   1           master transaction request
//  m_we      in   1           1=write, 0=read; valid with m_req
//  m_addr    in   AW          transaction address
//  m_wdata   in   DW          write data
//  m_gnt     out  1           controller ready; transfer accepted when m_req&m_gnt
//  m_done    out  1           one-cycle completion pulse
//  m_rdata   out  DW          read data, valid while m_done
//  m_err     out  2           status, valid while m_done: 00 ok, 01 no hit, 10 multi hit, 11 timeout
//  s_req     out  N_SLAVES    per-slave request, held until that slave acks
//  s_we      out  1           registered copy of m_we
//  s_addr    out  AW          registered copy of m_addr
//  s_wdata   out  DW          registered copy of m_wdata
//  s_ack     in   N_SLAVES    per-slave acknowledge pulse
//  s_hit     in   N_SLAVES    slave claims address; sampled only with its s_ack
//  s_rdata   in   N_SLAVES*DW slave i read data in [i*DW +: DW]; sampled with s_ack[i]&s_hit[i]
// BEHAVIOUR
//  Reset (async assert, sync deassert): state IDLE; all outputs 0 except m_gnt=1;
//    ack/hit masks, captured rdata and timer cleared.
//  FSM states: IDLE, JOIN, DONE.
//  IDLE
//   - m_gnt=1.
//   - On m_req: register we/addr/wdata to s_*; clear masks, timer and rdata; go JOIN.
//  JOIN
//   - m_gnt=0.
//   - s_req[i]=1 while ack_seen[i]=0.
//   - Acks with s_req[i]=0 are ignored: no duplicate counting, no rdata overwrite.
//   - Accepted ack[i]: set ack_seen[i]; set hit_seen[i] if s_hit[i].
//   - Read data: on a read, the first accepted hit captures s_rdata[i].
//   - Same-cycle hits: the lowest index wins.
//   - Later hits never overwrite; writes leave rdata at 0.
//   - If (ack_seen | accepted acks) is all ones: go DONE.
//   - Else if timer==TIMEOUT-1: go DONE with timeout flagged.
//   - Else timer++.
//   - s_req drops to 0 for all slaves on leaving JOIN.
//  DONE
//   - m_done=1 for exactly one cycle; m_gnt=0; go IDLE.
//   - m_err priority: timeout(11) > popcount(hit)>1 (10) > hit==0 (01) > ok(00).
//   - m_rdata = captured data; 0 when no hit or on a write.
//   - On timeout, m_rdata = data from any hit received before the abort.
//  Latency
//   - Acceptance at cycle 0; s_req high in cycle 1.
//   - Fastest completion (all acks in cycle 1): m_done in cycle 2.
//   - Timeout: JOIN lasts TIMEOUT cycles; m_done in cycle TIMEOUT+1.
//  Back-to-back: a new m_req is not accepted in DONE; the earliest next acceptance is the IDLE cycle after.
//  Reset mid-operation: s_req and m_done drop immediately; no completion for the aborted transaction.
// TESTING
//  1 Write a=0x10 d=0xA5; acks cyc 1,3,2,1; only slave2 hits
//    -> s_req bits drop per ack; m_done cyc 4; err 00; rdata 0x00.
//  2 Read a=0x40; slave1 hit rdata 0x3C; all ack cyc 1 -> m_done cyc 2; rdata 0x3C; err 00.
//  3 Read, all ack, no hit -> err 01, rdata 0x00; repeat ack from slave0 in same JOIN ignored.
//  4 Read; slaves 0,3 hit same cycle with 0x11/0x22 -> err 10, rdata 0x11.
//  5 Slave3 never acks, TIMEOUT=16 -> s_req[3] high 16 cycles; m_done cyc 17; err 11.
//  6 reset_n low mid-JOIN -> s_req=0 same cycle, m_gnt=1 after release; next read completes err 00.

Source files
------------

// File: rtl/bus_forkjoin_ctrl.sv
// Fork/join bus controller: broadcasts one master transaction to all slaves, waits for
// every acknowledge (or a timeout), then returns the claiming slave's data and a status.
module bus_forkjoin_ctrl #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   m_req,
  input  logic                   m_we,
  input  logic [AW-1:0]          m_addr,
  input  logic [DW-1:0]          m_wdata,
  output logic                   m_gnt,
  output logic                   m_done,
  output logic [DW-1:0]          m_rdata,
  output logic [1:0]             m_err,
  output logic [N_SLAVES-1:0]    s_req,
  output logic                   s_we,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_wdata,
  input  logic [N_SLAVES-1:0]    s_ack,
  input  logic [N_SLAVES-1:0]    s_hit,
  input  logic [N_SLAVES*DW-1:0] s_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StJoin, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_SLAVES-1:0] ack_seen_q, hit_seen_q;
  logic [DW-1:0]       rdata_q;
  logic [TW-1:0]       timer_q;
  logic                timeout_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;

  logic [N_SLAVES-1:0] acc_ack, acc_hit;
  logic                all_acked, timer_last;
  logic                cap_en;
  logic [DW-1:0]       cap_data;

  // Only acks from slaves still being requested count; repeats are dropped here.
  assign acc_ack    = s_ack & s_req;
  assign acc_hit    = acc_ack & s_hit;
  assign all_acked  = &(ack_seen_q | acc_ack);
  assign timer_last = (timer_q == TW'(TIMEOUT - 1));

  // Lowest-index accepted hit supplies the read data.
  always_comb begin
    cap_en   = 1'b0;
    cap_data = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (!cap_en && acc_hit[i]) begin
        cap_en   = 1'b1;
        cap_data = s_rdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (m_req) state_d = StJoin;
      StJoin:  if (all_acked || timer_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_gnt   = 1'b0;
    m_done  = 1'b0;
    s_req   = '0;
    m_rdata = '0;
    m_err   = 2'b00;
    unique case (state_q)
      StIdle: m_gnt = 1'b1;
      StJoin: s_req = ~ack_seen_q;
      StDone: begin
        m_done  = 1'b1;
        m_rdata = rdata_q;
        if (timeout_q)                              m_err = 2'b11;
        else if ((hit_seen_q & (hit_seen_q - 1'b1)) != '0) m_err = 2'b10;
        else if (hit_seen_q == '0)                  m_err = 2'b01;
        else                                        m_err = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_seen_q <= '0;
      hit_seen_q <= '0;
      rdata_q    <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (state_q == StIdle && m_req) begin
        ack_seen_q <= '0;
        hit_seen_q <= '0;
        rdata_q    <= '0;
        timer_q    <= '0;
        timeout_q  <= 1'b0;
        we_q       <= m_we;
        addr_q     <= m_addr;
        wdata_q    <= m_wdata;
      end else if (state_q == StJoin) begin
        ack_seen_q <= ack_seen_q | acc_ack;
        hit_seen_q <= hit_seen_q | acc_hit;
        if (!we_q && hit_seen_q == '0 && cap_en) begin
          rdata_q <= cap_data;
        end
        if (!all_acked) begin
          if (timer_last) begin
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      end
    end
  end

  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_bus_forkjoin_ctrl.sv
// Directed bench for bus_forkjoin_ctrl: stimulus pushes expected completions into a queue,
// a negedge monitor pops and compares whenever m_done is seen.
module tb_bus_forkjoin_ctrl;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt, m_done;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_err;
  logic [N-1:0]  s_req, s_ack, s_hit;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [N*DW-1:0] s_rdata;

  bus_forkjoin_ctrl #(.N_SLAVES(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_hit(s_hit), .s_rdata(s_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] rd;
    logic [1:0]    err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc_cnt = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && m_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(m_done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", 32'(cyc_cnt), 32'(e.cyc));
        check("rdata", 32'(m_rdata), 32'(e.rd));
        check("err", 32'(m_err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One transaction. aN = ack cycle of slave N (0 = never), hit = hit mask, rdv = slave data,
  // dup = cycle at which slave0 re-acks with a hit (0 = none), lat = expected m_done cycle.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int a0, input int a1, input int a2, input int a3,
                         input logic [N-1:0] hit, input logic [N*DW-1:0] rdv, input int dup,
                         input int lat, input logic [DW-1:0] exp_rd, input logic [1:0] exp_err);
    int ack_c[N];
    logic [N-1:0] exp_req;
    exp_t e;
    ack_c[0] = a0; ack_c[1] = a1; ack_c[2] = a2; ack_c[3] = a3;
    check("gnt_idle", 32'(m_gnt), 32'd1);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; s_rdata = rdv;
    e.rd = exp_rd; e.err = exp_err; e.cyc = cyc_cnt + lat;
    exp_q.push_back(e);
    for (int c = 1; c <= lat; c++) begin
      step();
      m_req = 1'b0;
      if (c == 1) begin
        check("s_we", 32'(s_we), 32'(we));
        check("s_addr", 32'(s_addr), 32'(addr));
        check("s_wdata", 32'(s_wdata), 32'(wd));
      end
      check("gnt_busy", 32'(m_gnt), 32'd0);
      for (int i = 0; i < N; i++)
        exp_req[i] = (c < lat) && (ack_c[i] == 0 || c <= ack_c[i]);
      check("s_req", 32'(s_req), 32'(exp_req));
      s_ack = '0; s_hit = '0;
      if (c < lat) begin
        for (int i = 0; i < N; i++) begin
          if (ack_c[i] == c) begin
            s_ack[i] = 1'b1;
            s_hit[i] = hit[i];
          end
        end
        if (dup == c) begin
          s_ack[0] = 1'b1;
          s_hit[0] = 1'b1;
        end
      end
    end
    step();
    s_ack = '0; s_hit = '0;
    check("gnt_after", 32'(m_gnt), 32'd1);
    check("done_low", 32'(m_done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_hit = '0; s_rdata = '0;
    #1;
    check("rst_gnt", 32'(m_gnt), 32'd1);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_sreq", 32'(s_req), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    check("rst_rdata", 32'(m_rdata), 32'd0);
    check("rst_saddr", 32'(s_addr), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: write, acks 1,3,2,1, slave2 hits; rdata stays 0 on a write
    run_txn(1'b1, 8'h10, 8'hA5, 1, 3, 2, 1, 4'b0100, {8'h00, 8'h99, 8'h00, 8'h00}, 0,
            4, 8'h00, 2'b00);
    // 2: read, slave1 hits with 0x3C, all ack cycle 1
    run_txn(1'b0, 8'h40, 8'h00, 1, 1, 1, 1, 4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00}, 0,
            2, 8'h3C, 2'b00);
    // 3: read, no hit; slave0 re-acks with a hit after its first ack and must be ignored
    run_txn(1'b0, 8'h41, 8'h00, 1, 2, 2, 3, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h77}, 2,
            4, 8'h00, 2'b01);
    // 4: read, slaves 0 and 3 hit together -> multi hit, lowest index data
    run_txn(1'b0, 8'h42, 8'h00, 1, 1, 1, 1, 4'b1001, {8'h22, 8'h00, 8'h00, 8'h11}, 0,
            2, 8'h11, 2'b10);
    // 5: slave3 never acks -> timeout; slave1's earlier hit data is still returned
    run_txn(1'b0, 8'h43, 8'h00, 1, 2, 1, 0, 4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00}, 0,
            TO + 1, 8'h5A, 2'b11);
    // 6b: a late hit after an earlier one does not overwrite the data
    run_txn(1'b0, 8'h44, 8'h00, 2, 1, 1, 1, 4'b0011, {8'h00, 8'h00, 8'h66, 8'h55}, 0,
            3, 8'h66, 2'b10);

    // 6: reset in the middle of JOIN
    check("gnt_pre_rst", 32'(m_gnt), 32'd1);
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h50;
    step();
    m_req = 1'b0;
    check("sreq_join", 32'(s_req), 32'hF);
    step();
    reset_n = 1'b0;
    #1;
    check("sreq_rst", 32'(s_req), 32'd0);
    check("done_rst", 32'(m_done), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("gnt_post_rst", 32'(m_gnt), 32'd1);
    run_txn(1'b0, 8'h51, 8'h00, 2, 1, 1, 1, 4'b0100, {8'h00, 8'hC3, 8'h00, 8'h00}, 0,
            3, 8'hC3, 2'b00);

    step(); step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
